// File: rtl/knn_pkg.sv
// Shared KNN types and constants used by the classifier datapath and the
// result reporter.
`timescale 1ns/1ps
package knn_pkg;

  localparam logic [7:0] KNN_SYNC_BYTE = 8'hA5;
  localparam int         KNN_FRAME_LEN = 7;

  typedef logic [1:0]        class_t;
  typedef logic signed [7:0] coord_t;
  typedef logic [15:0]       latency_t;

  function automatic logic [7:0] knn_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3, input logic [7:0] b4,
                                              input logic [7:0] b5);
    return b1 ^ b2 ^ b3 ^ b4 ^ b5;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer. A load in the last cycle of a stop bit chains
// the next byte with no idle time between the two bytes.
`timescale 1ns/1ps
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_BIT = 4'd9;

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done     = 1'b0;
    if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (bit_q == STOP_BIT) begin
          done     = 1'b1;
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[7:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (load) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = 4'd0;
      tx_d     = 1'b0;
      shift_d  = data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/knn_result_uart_tx.sv
// Captures one KNN classification result and sends it to the host as a
// 7-byte UART frame: A5, x, y, {k,class}, lat_hi, lat_lo, xor checksum.
`timescale 1ns/1ps
module knn_result_uart_tx
  import knn_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     result_valid,
  input  coord_t   x_in,
  input  coord_t   y_in,
  input  class_t   class_in,
  input  logic     k_mode_in,
  input  latency_t latency_in,
  output logic     tx,
  output logic     busy,
  output logic     frame_sent,
  output logic [3:0] overrun_cnt
);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("knn_result_uart_tx: CLKS_PER_BIT must be >= 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_NEXT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [2:0] LAST_IDX = 3'(KNN_FRAME_LEN - 1);

  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      ovr_q, ovr_d;
  logic [5:0][7:0] buf_q, buf_d;
  logic [7:0]      b3;
  logic            ser_load, ser_done;
  logic [7:0]      ser_data;

  assign b3          = {5'b0, k_mode_in, class_in};
  assign busy        = (state_q == ST_SEND) || (state_q == ST_NEXT);
  assign frame_sent  = (state_q == ST_DONE);
  assign overrun_cnt = ovr_q;

  // The next byte is loaded in the same cycle the serializer reports done,
  // so NEXT overlaps the new start bit and the final byte skips straight to DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    ovr_d    = ovr_q;
    ser_load = 1'b0;
    ser_data = KNN_SYNC_BYTE;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (result_valid) begin
          state_d  = ST_SEND;
          idx_d    = 3'd0;
          ser_load = 1'b1;
          buf_d    = {knn_checksum(x_in, y_in, b3, latency_in[15:8], latency_in[7:0]),
                      latency_in[7:0], latency_in[15:8], b3, y_in, x_in};
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            ser_load = 1'b1;
            ser_data = buf_q[0];
            buf_d    = {8'h00, buf_q[5:1]};
            state_d  = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        idx_d   = idx_q + 3'd1;
        state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
    if (busy && result_valid && (ovr_q != 4'hF)) ovr_d = ovr_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      ovr_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: the shadow buffer holds data only and is always rewritten on capture, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load),
    .data  (ser_data),
    .tx    (tx),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_knn_result_uart_tx.sv
// Directed bench for knn_result_uart_tx at 10 clocks per UART bit: decodes
// each frame from tx samples and checks bytes, bit timing and handshakes.
`timescale 1ns/1ps
module tb_knn_result_uart_tx;

  localparam int FRAME_CYC = 700;

  logic        clk = 1'b0;
  logic        reset;
  logic        result_valid;
  logic [7:0]  x_in, y_in;
  logic [1:0]  class_in;
  logic        k_mode_in;
  logic [15:0] latency_in;
  logic        tx, busy, frame_sent;
  logic [3:0]  overrun_cnt;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        samp_tx [FRAME_CYC];
  logic [7:0]  rx_bytes [7];
  int          busy_cnt, fs_cnt;

  always #5 clk = ~clk;

  knn_result_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .result_valid (result_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .class_in     (class_in),
    .k_mode_in    (k_mode_in),
    .latency_in   (latency_in),
    .tx           (tx),
    .busy         (busy),
    .frame_sent   (frame_sent),
    .overrun_cnt  (overrun_cnt)
  );

  // Called at a negedge in cycle t; returns at the negedge of cycle t+1.
  task automatic drive_result(input logic [7:0] x, input logic [7:0] y, input logic [1:0] c,
                              input logic k, input logic [15:0] lat);
    x_in = x; y_in = y; class_in = c; k_mode_in = k; latency_in = lat;
    result_valid = 1'b1;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("FAIL idle_before_start: busy=%b expected 0", busy);
    end
    @(negedge clk);
    result_valid = 1'b0;
    vec_cnt++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL start_at_t1: tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    end
  endtask

  // Samples cycles t+1..t+700, optionally firing overrun pulses; ends at t+701.
  task automatic capture_frame(input int ovr_mode);
    busy_cnt = 0;
    fs_cnt   = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      samp_tx[i] = tx;
      if (busy === 1'b1) busy_cnt++;
      if (frame_sent !== 1'b0) fs_cnt++;
      result_valid = (ovr_mode == 1 && (i == 49 || i == 299 || i == 599)) ||
                     (ovr_mode == 2 && i >= 20 && i < 420 && (i % 20) == 0);
      if (result_valid) begin
        x_in = 8'(i); y_in = 8'(~i); class_in = 2'(i); k_mode_in = 1'b1; latency_in = 16'hBEEF;
      end
      @(negedge clk);
    end
    result_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [55:0] exp);
    int   bad;
    logic v;
    bad = 0;
    for (int b = 0; b < 7; b++) begin
      for (int j = 0; j < 10; j++) begin
        v = samp_tx[(b * 10 + j) * 10];
        for (int s = 1; s < 10; s++)
          if (samp_tx[(b * 10 + j) * 10 + s] !== v) bad++;
        if (j == 0 && v !== 1'b0) bad++;
        if (j == 9 && v !== 1'b1) bad++;
        if (j >= 1 && j <= 8) rx_bytes[b][j-1] = v;
      end
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++; $display("FAIL %s bit_timing: %0d bad samples expected 0", name, bad);
    end
    for (int b = 0; b < 7; b++) begin
      vec_cnt++;
      if (rx_bytes[b] !== exp[55 - 8 * b -: 8]) begin
        err_cnt++;
        $display("FAIL %s byte%0d: got %h expected %h", name, b, rx_bytes[b], exp[55 - 8 * b -: 8]);
      end
    end
    vec_cnt++;
    if (busy_cnt != FRAME_CYC || fs_cnt != 0) begin
      err_cnt++;
      $display("FAIL %s busy_window: busy_cycles=%0d early_frame_sent=%0d expected 700 and 0",
               name, busy_cnt, fs_cnt);
    end
    vec_cnt++;
    if (frame_sent !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s frame_end: frame_sent=%b busy=%b tx=%b expected 1 0 1",
               name, frame_sent, busy, tx);
    end
  endtask

  task automatic expect_pulse_ends(input string name);
    @(negedge clk);
    vec_cnt++;
    if (frame_sent !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s after_end: frame_sent=%b busy=%b tx=%b expected 0 0 1",
               name, frame_sent, busy, tx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; result_valid = 1'b0;
    x_in = 8'h00; y_in = 8'h00; class_in = 2'd0; k_mode_in = 1'b0; latency_in = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_sent !== 1'b0 || overrun_cnt !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_state: tx=%b busy=%b frame_sent=%b overrun=%0d expected 1 0 0 0",
               tx, busy, frame_sent, overrun_cnt);
    end
  endtask

  task automatic test_basic_frame();
    drive_result(8'h05, 8'hFD, 2'd2, 1'b1, 16'h0123);
    capture_frame(0);
    check_frame("basic", 56'hA5_05_FD_06_01_23_DC);
    expect_pulse_ends("basic");
  endtask

  task automatic test_overrun();
    drive_result(8'h11, 8'h22, 2'd1, 1'b0, 16'h0456);
    capture_frame(1);
    check_frame("overrun3", 56'hA5_11_22_01_04_56_60);
    vec_cnt++;
    if (overrun_cnt !== 4'd3) begin
      err_cnt++; $display("FAIL overrun_count: got %0d expected 3", overrun_cnt);
    end
    expect_pulse_ends("overrun3");
    drive_result(8'hE0, 8'h10, 2'd3, 1'b1, 16'h8001);
    capture_frame(2);
    check_frame("overrun20", 56'hA5_E0_10_07_80_01_76);
    vec_cnt++;
    if (overrun_cnt !== 4'd15) begin
      err_cnt++; $display("FAIL overrun_saturate: got %0d expected 15", overrun_cnt);
    end
    expect_pulse_ends("overrun20");
  endtask

  task automatic test_back_to_back();
    drive_result(8'h01, 8'h02, 2'd0, 1'b0, 16'h0000);
    capture_frame(0);
    check_frame("b2b_first", 56'hA5_01_02_00_00_00_03);
    drive_result(8'hFE, 8'h81, 2'd1, 1'b1, 16'hABCD);
    capture_frame(0);
    check_frame("b2b_second", 56'hA5_FE_81_05_AB_CD_1C);
    expect_pulse_ends("b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    int stray;
    drive_result(8'h33, 8'h44, 2'd2, 1'b0, 16'h1234);
    for (int i = 0; i < 332; i++) begin
      result_valid = (i == 99);
      @(negedge clk);
    end
    reset = 1'b1; result_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; result_valid = 1'b0;
    vec_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_frame: tx=%b busy=%b overrun=%0d expected 1 0 0", tx, busy, overrun_cnt);
    end
    stray = 0;
    for (int i = 0; i < 800; i++) begin
      if (frame_sent !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    vec_cnt++;
    if (stray != 0) begin
      err_cnt++; $display("FAIL abandoned_frame: %0d active cycles expected 0", stray);
    end
    drive_result(8'h7A, 8'hC3, 2'd3, 1'b0, 16'h0F0E);
    capture_frame(0);
    check_frame("after_reset", 56'hA5_7A_C3_03_0F_0E_BB);
    expect_pulse_ends("after_reset");
  endtask

  task automatic test_signed_extremes();
    drive_result(8'h80, 8'h7F, 2'd0, 1'b0, 16'hFFFF);
    capture_frame(0);
    check_frame("extremes", 56'hA5_80_7F_00_FF_FF_FF);
    expect_pulse_ends("extremes");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_signed_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
